// File: rtl/axi_mode_pkg.sv
// Shared definitions for the AXI read/write address mode decoders:
// burst FSM state encoding, AXI response codes and the AxLEN width.
package axi_mode_pkg;

  // Burst-tracking FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } ar_state_e;

  // AXI RRESP/BRESP encodings used by the wrapper around the decoder
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // AXI4 burst length field width
  localparam int ARLEN_W = 8;

  // Response code the wrapper should return for a burst with the given error flag
  function automatic logic [1:0] resp_for(input logic dec_err);
    return dec_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ar_addr_window_dec.sv
// Combinational address-window decoder: maps an address onto one of NUM_CH
// equally spaced channel addresses starting at BASE_ADDR, spaced by
// 1 << STRIDE_LG2. IDLE_ADDR is recognised separately and always wins over a
// channel hit. Shared by the read- and write-address paths.
module ar_addr_window_dec #(
  parameter int                ADDR_W     = 32,
  parameter int                NUM_CH     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h10,
  parameter int                STRIDE_LG2 = 0,
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = '0,
  parameter int                CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic              idle,
  output logic [CH_W-1:0]   ch
);

  // Low offset bits that must be zero for an address to sit on a channel
  // boundary; all-zero when STRIDE_LG2 is 0, so every offset is aligned.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << STRIDE_LG2) - 64'd1);
  localparam logic [ADDR_W-1:0] NUM_CH_A   = ADDR_W'(NUM_CH);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;
  logic              above_base;
  logic              aligned;
  logic              in_range;

  // Offset from channel 0, alignment and range test, then idle priority
  always_comb begin
    off        = addr - BASE_ADDR;
    idx        = off >> STRIDE_LG2;
    above_base = (addr >= BASE_ADDR);
    aligned    = ((off & ALIGN_MASK) == '0);
    in_range   = (idx < NUM_CH_A);
    idle       = (addr == IDLE_ADDR);
    hit        = !idle && above_base && aligned && in_range;
    ch         = idx[CH_W-1:0];
  end

endmodule

// File: rtl/axi_ar_mode_decoder.sv
// AXI slave read-address mode decoder. Accepts one AR at a time, decodes
// ARADDR into a one-hot channel read enable and holds it until the last R
// beat of the burst. Unmapped addresses raise dec_err for the burst;
// IDLE_ADDR clears every enable without an error.
// Optional build macro AR_DEC_ERR_CNT_EN adds a saturating 16-bit count of
// decode misses (err_cnt) with a synchronous clear input (err_cnt_clr).
module axi_ar_mode_decoder
  import axi_mode_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                NUM_CH     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h10,
  parameter int                STRIDE_LG2 = 0,
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = '0,
  parameter int                STICKY     = 0,
  parameter int                CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               ARVALID,
  output logic               ARREADY,
  input  logic [ADDR_W-1:0]  ARADDR,
  input  logic [ARLEN_W-1:0] ARLEN,
  input  logic               RVALID,
  input  logic               RREADY,
  output logic [NUM_CH-1:0]  rd_en,
  output logic [CH_W-1:0]    rd_ch,
  output logic               busy,
  output logic               dec_err
`ifdef AR_DEC_ERR_CNT_EN
  ,
  input  logic               err_cnt_clr,
  output logic [15:0]        err_cnt
`endif
);

  // Sticky mode keeps the last channel enabled between bursts
  localparam bit STICKY_EN = (STICKY != 0);

  ar_state_e          state;
  logic [ARLEN_W-1:0] len_q;
  logic [ARLEN_W-1:0] beat_cnt;

  logic               dec_hit;
  logic               dec_idle;
  logic [CH_W-1:0]    dec_ch;
  logic [NUM_CH-1:0]  dec_onehot;

  logic               ar_hs;
  logic               r_beat;
  logic               last_beat;

  ar_addr_window_dec #(
    .ADDR_W     (ADDR_W),
    .NUM_CH     (NUM_CH),
    .BASE_ADDR  (BASE_ADDR),
    .STRIDE_LG2 (STRIDE_LG2),
    .IDLE_ADDR  (IDLE_ADDR),
    .CH_W       (CH_W)
  ) u_dec (
    .addr (ARADDR),
    .hit  (dec_hit),
    .idle (dec_idle),
    .ch   (dec_ch)
  );

  // One-hot expansion of the decoded channel index
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
      assign dec_onehot[gi] = (dec_ch == CH_W'(gi));
    end
  endgenerate

  // ARREADY is only ever high in IDLE, so this is the accepted-AR strobe
  assign ar_hs     = ARVALID && ARREADY;
  assign r_beat    = RVALID && RREADY;
  assign last_beat = r_beat && (beat_cnt == len_q);

  // Burst FSM with registered ARREADY, enable, channel, busy and error outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      ARREADY  <= 1'b0;
      rd_en    <= '0;
      rd_ch    <= '0;
      busy     <= 1'b0;
      dec_err  <= 1'b0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            len_q    <= ARLEN;
            beat_cnt <= '0;
            busy     <= 1'b1;
            ARREADY  <= 1'b0;
            if (dec_idle) begin
              // Deliberate "no channel" access: burst still tracked
              state   <= ACTIVE;
              rd_en   <= '0;
              dec_err <= 1'b0;
            end else if (dec_hit) begin
              state   <= ACTIVE;
              rd_en   <= dec_onehot;
              rd_ch   <= dec_ch;
              dec_err <= 1'b0;
            end else begin
              // Unmapped: sticky mode keeps whatever channel was held
              state   <= ERR;
              dec_err <= 1'b1;
              if (!STICKY_EN) begin
                rd_en <= '0;
              end
            end
          end else begin
            // Also raises ARREADY on the first cycle out of reset
            ARREADY <= 1'b1;
          end
        end

        ACTIVE, ERR: begin
          if (last_beat) begin
            state    <= IDLE;
            ARREADY  <= 1'b1;
            busy     <= 1'b0;
            dec_err  <= 1'b0;
            beat_cnt <= '0;
            if (!STICKY_EN) begin
              rd_en <= '0;
            end
          end else if (r_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          ARREADY  <= 1'b0;
          rd_en    <= '0;
          busy     <= 1'b0;
          dec_err  <= 1'b0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

`ifdef AR_DEC_ERR_CNT_EN
  logic miss_hs;

  assign miss_hs = (state == IDLE) && ar_hs && !dec_idle && !dec_hit;

  // Saturating decode-miss counter; a clear coinciding with a miss leaves 1
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= miss_hs ? 16'd1 : 16'd0;
    end else if (miss_hs && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_ar_mode_decoder.sv
// Bench for axi_ar_mode_decoder: two instances (STICKY=0 and STICKY=1) share
// one stimulus stream. Each accepted AR pushes its expected start and end
// states into a scoreboard; a negedge monitor pops them on busy edges and
// checks the held enables every cycle.
module tb_axi_ar_mode_decoder;

  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'h10;
  localparam logic [31:0] IDLA = 32'h0;

  logic        ACLK    = 1'b0;
  logic        ARESETn = 1'b0;
  logic        ARVALID = 1'b0;
  logic [31:0] ARADDR  = '0;
  logic [7:0]  ARLEN   = '0;
  logic        RVALID  = 1'b0;
  logic        RREADY  = 1'b0;

  logic       arready0, arready1, busy0, busy1, err0, err1;
  logic [3:0] en0, en1;
  logic [1:0] ch0, ch1;
`ifdef AR_DEC_ERR_CNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [15:0] ecnt0, ecnt1;
`endif

  always #5 ACLK = ~ACLK;

  axi_ar_mode_decoder #(
    .ADDR_W(32), .NUM_CH(NCH), .BASE_ADDR(BASE), .STRIDE_LG2(2),
    .IDLE_ADDR(IDLA), .STICKY(0), .CH_W(2)
  ) dut_ns (
    .ACLK(ACLK), .ARESETn(ARESETn), .ARVALID(ARVALID), .ARREADY(arready0),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .RVALID(RVALID), .RREADY(RREADY),
    .rd_en(en0), .rd_ch(ch0), .busy(busy0), .dec_err(err0)
`ifdef AR_DEC_ERR_CNT_EN
    , .err_cnt_clr(err_cnt_clr), .err_cnt(ecnt0)
`endif
  );

  axi_ar_mode_decoder #(
    .ADDR_W(32), .NUM_CH(NCH), .BASE_ADDR(BASE), .STRIDE_LG2(2),
    .IDLE_ADDR(IDLA), .STICKY(1), .CH_W(2)
  ) dut_s (
    .ACLK(ACLK), .ARESETn(ARESETn), .ARVALID(ARVALID), .ARREADY(arready1),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .RVALID(RVALID), .RREADY(RREADY),
    .rd_en(en1), .rd_ch(ch1), .busy(busy1), .dec_err(err1)
`ifdef AR_DEC_ERR_CNT_EN
    , .err_cnt_clr(err_cnt_clr), .err_cnt(ecnt1)
`endif
  );

  typedef struct packed {
    bit         is_end;
    logic [3:0] en_ns;
    logic [3:0] en_s;
    bit         chk_ch;
    logic [1:0] ch;
    bit         err;
  } exp_t;

  exp_t sb[$];
  exp_t cur = '0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic busy_prev = 1'b0;
  logic [3:0] held_s = '0;
  int   model_err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode: -2 = idle address, -1 = unmapped, else channel number
  function automatic int model_decode(input logic [31:0] a);
    longint unsigned d;
    if (a == IDLA) return -2;
    if (a < BASE) return -1;
    d = longint'(a) - longint'(BASE);
    if ((d % 4) != 0) return -1;
    if ((d / 4) >= NCH) return -1;
    return int'(d / 4);
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1:    return BASE + 32'(4 * $urandom_range(0, 3));
      2:       return IDLA;
      3:       return BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
      4:       return 32'h20 + 32'($urandom_range(0, 64));
      default: return $urandom;
    endcase
  endfunction

  // Present one AR, wait (bounded) for the handshake, push expectations
  task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input bit clr);
    int   k;
    int   cyc;
    exp_t s;
    exp_t e;
    ARADDR  = addr;
    ARLEN   = len;
    ARVALID = 1'b1;
    cyc = 0;
    while (arready0 !== 1'b1 && cyc < 50) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    if (cyc >= 50) begin
      check("ar_handshake_timeout", 32'd0, 32'd1);
      ARVALID = 1'b0;
      return;
    end
`ifdef AR_DEC_ERR_CNT_EN
    err_cnt_clr = clr;
`endif
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    ARADDR  = $urandom;
    ARLEN   = 8'($urandom);
`ifdef AR_DEC_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    k = model_decode(addr);
    s = '0;
    e = '0;
    e.is_end = 1'b1;
    if (k >= 0) begin
      s.en_ns  = 4'(1 << k);
      s.en_s   = 4'(1 << k);
      s.chk_ch = 1'b1;
      s.ch     = 2'(k);
      held_s   = 4'(1 << k);
    end else if (k == -2) begin
      held_s   = '0;
    end else begin
      s.en_s = held_s;
      s.err  = 1'b1;
    end
    e.en_s = held_s;
    if (clr) model_err_cnt = (k == -1) ? 1 : 0;
    else if (k == -1 && model_err_cnt < 65535) model_err_cnt++;
    sb.push_back(s);
    sb.push_back(e);
    $display("[TB] AR addr=0x%08h len=%0d kind=%0d", addr, len, k);
  endtask

  // Drive R beats until len+1 have completed; stray ARVALID pulses mid-burst
  task automatic do_beats(input int len, input bit stall);
    int beats = 0;
    int cyc = 0;
    while (beats <= len && cyc < 2000) begin
      RVALID = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      RREADY = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (beats < len && $urandom_range(0, 2) == 0) begin
        ARVALID = 1'b1;
        ARADDR  = pick_addr();
      end else begin
        ARVALID = 1'b0;
      end
      @(posedge ACLK); #1;
      cyc++;
      if (RVALID && RREADY) beats++;
      if (beats <= len) check("busy_mid_burst", 32'(busy0), 32'd1);
    end
    RVALID  = 1'b0;
    RREADY  = 1'b0;
    ARVALID = 1'b0;
    if (cyc >= 2000) check("beat_timeout", 32'd0, 32'd1);
    else check("busy_after_last_beat", 32'(busy0), 32'd0);
  endtask

  // Scoreboard monitor: pop on busy edges, check held state every cycle
  always @(negedge ACLK) begin
    exp_t e;
    if (mon_en) begin
      if (busy0 && !busy_prev) begin
        if (sb.size() == 0) begin
          check("sb_underflow_start", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("start_event_order", 32'(e.is_end), 32'd0);
          cur = e;
          if (e.chk_ch) begin
            check("rd_ch_ns", 32'(ch0), 32'(e.ch));
            check("rd_ch_s", 32'(ch1), 32'(e.ch));
          end
        end
      end else if (!busy0 && busy_prev) begin
        if (sb.size() == 0) begin
          check("sb_underflow_end", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("end_event_order", 32'(e.is_end), 32'd1);
          cur = e;
        end
      end
      check("rd_en_ns", 32'(en0), 32'(cur.en_ns));
      check("rd_en_s", 32'(en1), 32'(cur.en_s));
      check("dec_err_ns", 32'(err0), 32'(cur.err));
      check("dec_err_s", 32'(err1), 32'(cur.err));
      check("busy_pair", 32'(busy1), 32'(busy0));
      check("arready_ns", 32'(arready0), 32'(!busy0));
      check("arready_s", 32'(arready1), 32'(!busy1));
    end
    busy_prev = busy0;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, {24'd0, en0, en1}, 32'd0);
    check({tag, "_rd_ch"}, {28'd0, ch0, ch1}, 32'd0);
    check({tag, "_busy"}, {30'd0, busy0, busy1}, 32'd0);
    check({tag, "_dec_err"}, {30'd0, err0, err1}, 32'd0);
    check({tag, "_arready"}, {30'd0, arready0, arready1}, 32'd0);
`ifdef AR_DEC_ERR_CNT_EN
    check({tag, "_err_cnt"}, {ecnt0, ecnt1}, 32'd0);
`endif
  endtask

  task automatic release_reset();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    check("arready_before_first_edge", 32'(arready0), 32'd0);
    @(posedge ACLK); #1;
    check("arready_after_release_ns", 32'(arready0), 32'd1);
    check("arready_after_release_s", 32'(arready1), 32'd1);
    cur    = '0;
    mon_en = 1'b1;
  endtask

  initial begin
    // Reset held for 3 cycles
    repeat (3) @(posedge ACLK);
    #1;
    check_all_zero("reset");
    release_reset();

    // Single-beat hit, stalled 4-beat burst, two kinds of miss
    do_ar(32'h14, 8'd0, 1'b0);
    do_beats(0, 1'b0);
    do_ar(32'h10, 8'd3, 1'b0);
    do_beats(3, 1'b1);
    do_ar(32'h22, 8'd1, 1'b0);
    do_beats(1, 1'b1);
    do_ar(32'h20, 8'd0, 1'b0);
    do_beats(0, 1'b0);
`ifdef AR_DEC_ERR_CNT_EN
    check("err_cnt_two_misses", {ecnt0, ecnt1}, {16'd2, 16'd2});
`endif

    // Sticky hold then explicit idle address
    do_ar(32'h18, 8'd2, 1'b0);
    do_beats(2, 1'b1);
    repeat (2) @(posedge ACLK);
    #1;
    do_ar(IDLA, 8'd0, 1'b0);
    do_beats(0, 1'b0);

    // Reset in the middle of an 8-beat burst
    do_ar(32'h10, 8'd7, 1'b0);
    RVALID = 1'b1;
    RREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    mon_en  = 1'b0;
    ARESETn = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    RVALID = 1'b0;
    RREADY = 1'b0;
    sb.delete();
    held_s = '0;
    model_err_cnt = 0;
    release_reset();
    do_ar(32'h1C, 8'd1, 1'b0);
    do_beats(1, 1'b1);

    // Randomized traffic, gaps of 0..2 cycles (0 = AR right after last beat)
    for (int t = 0; t < 80; t++) begin
      logic [7:0] len;
      len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 3));
      do_ar(pick_addr(), len, 1'b0);
      do_beats(int'(len), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge ACLK);
      #0;
    end

`ifdef AR_DEC_ERR_CNT_EN
    check("err_cnt_random_ns", 32'(ecnt0), 32'(model_err_cnt));
    check("err_cnt_random_s", 32'(ecnt1), 32'(model_err_cnt));
    do_ar(32'h22, 8'd0, 1'b1);
    do_beats(0, 1'b0);
    check("err_cnt_clr_with_miss", {ecnt0, ecnt1}, {16'd1, 16'd1});
`endif

    repeat (3) @(posedge ACLK);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
